// File: rtl/dvi_pll_pkg.sv
// Shared types and defaults for the DVI PLL lock supervisor.
// Defaults assume a 50 MHz reference clock.
package dvi_pll_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN,
    FAULT
  } pll_state_t;

  localparam int REFCLK_HZ            = 50_000_000;
  localparam int DEF_NUM_CLK          = 2;
  localparam int DEF_RST_PULSE_CYC    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYC = REFCLK_HZ / 1000;
  localparam int DEF_LOCK_STABLE_CYC  = 1024;
  localparam int DEF_STAGGER_CYC      = 8;
  localparam int DEF_MAX_RETRY        = 3;

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int cnt_w(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser for the asynchronous PLL lock indication.
// Clears to "unlocked" on reset.
module pll_lock_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/dvi_pll_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, qualifies lock, retries on
// timeout and releases the per-domain resets in a staggered order.
module dvi_pll_supervisor
  import dvi_pll_pkg::*;
#(
  parameter int NUM_CLK          = DEF_NUM_CLK,
  parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int STAGGER_CYC      = DEF_STAGGER_CYC,
  parameter int MAX_RETRY        = DEF_MAX_RETRY,
  localparam int RW              = cnt_w(MAX_RETRY + 1)
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               soft_restart,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic [NUM_CLK-1:0] domain_rst,
  output logic               ready,
  output logic               fault,
  output logic [RW-1:0]      retry_cnt,
  output logic [7:0]         lost_cnt
);

  localparam int PW  = cnt_w(RST_PULSE_CYC);
  localparam int TW  = cnt_w(LOCK_TIMEOUT_CYC);
  localparam int SW  = cnt_w(LOCK_STABLE_CYC);
  localparam int RLW = cnt_w(NUM_CLK * STAGGER_CYC + 1);

  localparam logic [PW-1:0]  PULSE_LAST = PW'(RST_PULSE_CYC - 1);
  localparam logic [TW-1:0]  TMO_LAST   = TW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [SW-1:0]  STAB_LAST  = SW'(LOCK_STABLE_CYC - 1);
  localparam logic [RLW-1:0] REL_LAST   = RLW'(NUM_CLK * STAGGER_CYC);
  localparam logic [RW-1:0]  RETRY_MAX  = RW'(MAX_RETRY);

  logic               w_lk;
  pll_state_t         r_state;
  logic [PW-1:0]      r_pulse;
  logic [TW-1:0]      r_tmo;
  logic [SW-1:0]      r_stab;
  logic [RLW-1:0]     r_rel;
  logic               r_pll_rst;
  logic [NUM_CLK-1:0] r_domain_rst;
  logic               r_ready;
  logic               r_fault;
  logic [RW-1:0]      r_retry;
  logic [7:0]         r_lost;

  pll_lock_sync u_sync (
    .i_clk   (refclk),
    .i_rst   (rst),
    .i_async (pll_locked),
    .o_sync  (w_lk)
  );

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state      <= RESET_PLL;
      r_pulse      <= '0;
      r_tmo        <= '0;
      r_stab       <= '0;
      r_rel        <= '0;
      r_pll_rst    <= 1'b1;
      r_domain_rst <= '1;
      r_ready      <= 1'b0;
      r_fault      <= 1'b0;
      r_retry      <= '0;
      r_lost       <= '0;
    end else if (soft_restart) begin
      r_state      <= RESET_PLL;
      r_pulse      <= '0;
      r_pll_rst    <= 1'b1;
      r_domain_rst <= '1;
      r_ready      <= 1'b0;
      r_fault      <= 1'b0;
      r_retry      <= '0;
    end else begin
      unique case (r_state)
        RESET_PLL: begin
          if (r_pulse == PULSE_LAST) begin
            r_state   <= WAIT_LOCK;
            r_pll_rst <= 1'b0;
            r_tmo     <= '0;
          end else begin
            r_pulse <= r_pulse + PW'(1);
          end
        end
        WAIT_LOCK, STABLE: begin
          // The timeout spans the whole lock attempt, glitches included.
          if (r_tmo == TMO_LAST) begin
            r_pll_rst <= 1'b1;
            if (r_retry == RETRY_MAX) begin
              r_state <= FAULT;
              r_fault <= 1'b1;
            end else begin
              r_state <= RESET_PLL;
              r_pulse <= '0;
              r_retry <= r_retry + RW'(1);
            end
          end else begin
            r_tmo <= r_tmo + TW'(1);
            if (r_state == WAIT_LOCK) begin
              if (w_lk) begin
                r_state <= STABLE;
                r_stab  <= '0;
              end
            end else if (!w_lk) begin
              r_state <= WAIT_LOCK;
            end else if (r_stab == STAB_LAST) begin
              r_state <= RELEASE;
              r_rel   <= '0;
            end else begin
              r_stab <= r_stab + SW'(1);
            end
          end
        end
        RELEASE, RUN: begin
          if (!w_lk) begin
            r_state      <= RESET_PLL;
            r_pulse      <= '0;
            r_pll_rst    <= 1'b1;
            r_domain_rst <= '1;
            r_ready      <= 1'b0;
            if (r_lost != 8'hFF) r_lost <= r_lost + 8'd1;
          end else if (r_state == RELEASE) begin
            if (r_rel == REL_LAST) begin
              r_state <= RUN;
              r_ready <= 1'b1;
              r_retry <= '0;
            end else begin
              r_rel <= r_rel + RLW'(1);
              for (int i = 0; i < NUM_CLK; i++) begin
                if (r_rel == RLW'((i + 1) * STAGGER_CYC - 1))
                  r_domain_rst[i] <= 1'b0;
              end
            end
          end
        end
        FAULT: begin
          r_pll_rst    <= 1'b1;
          r_domain_rst <= '1;
        end
        default: r_state <= RESET_PLL;
      endcase
    end
  end

  assign pll_rst    = r_pll_rst;
  assign domain_rst = r_domain_rst;
  assign ready      = r_ready;
  assign fault      = r_fault;
  assign retry_cnt  = r_retry;
  assign lost_cnt   = r_lost;

endmodule

// File: tb/tb_dvi_pll_supervisor.sv
// Randomised and directed bench for dvi_pll_supervisor with a
// per-cycle scoreboard fed by a phase/elapsed-time reference model.
module tb_dvi_pll_supervisor;

  localparam int N     = 3;
  localparam int PULSE = 4;
  localparam int TMO   = 64;
  localparam int STAB  = 8;
  localparam int S     = 3;
  localparam int RETRY = 2;

  localparam int PH_RST  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_STAB = 2;
  localparam int PH_REL  = 3;
  localparam int PH_RUN  = 4;
  localparam int PH_FLT  = 5;

  logic         refclk = 1'b0;
  logic         rst = 1'b1;
  logic         soft_restart = 1'b0;
  logic         pll_locked = 1'b0;
  logic         pll_rst;
  logic [N-1:0] domain_rst;
  logic         ready;
  logic         fault;
  logic [1:0]   retry_cnt;
  logic [7:0]   lost_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  // Reference model: phase, cycles elapsed in phase, cycles since PLL
  // reset release, consecutive qualified lock highs, retries, losses.
  int ph, el, tw, run, rc, lost;
  logic ms1, ms2;

  dvi_pll_supervisor #(
    .NUM_CLK          (N),
    .RST_PULSE_CYC    (PULSE),
    .LOCK_TIMEOUT_CYC (TMO),
    .LOCK_STABLE_CYC  (STAB),
    .STAGGER_CYC      (S),
    .MAX_RETRY        (RETRY)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .soft_restart (soft_restart),
    .pll_locked   (pll_locked),
    .pll_rst      (pll_rst),
    .domain_rst   (domain_rst),
    .ready        (ready),
    .fault        (fault),
    .retry_cnt    (retry_cnt),
    .lost_cnt     (lost_cnt)
  );

  always #5 refclk = ~refclk;

  function automatic void m_reset();
    ph = PH_RST; el = 0; tw = 0; run = 0; rc = 0; lost = 0;
    ms1 = 1'b0; ms2 = 1'b0;
  endfunction

  function automatic void m_edge(input logic sr, input logic pin);
    logic lk;
    lk = ms2; ms2 = ms1; ms1 = pin;
    if (sr) begin
      ph = PH_RST; el = 0; rc = 0;
    end else if (ph == PH_RST) begin
      el++;
      if (el == PULSE) begin ph = PH_WAIT; tw = 0; end
    end else if (ph == PH_WAIT || ph == PH_STAB) begin
      tw++;
      if (tw == TMO) begin
        if (rc == RETRY) ph = PH_FLT;
        else begin rc++; ph = PH_RST; el = 0; end
      end else if (ph == PH_WAIT) begin
        if (lk) begin ph = PH_STAB; run = 0; end
      end else if (!lk) begin
        ph = PH_WAIT;
      end else begin
        run++;
        if (run == STAB) begin ph = PH_REL; el = 0; end
      end
    end else if (ph == PH_REL || ph == PH_RUN) begin
      if (!lk) begin
        lost = (lost < 255) ? lost + 1 : 255;
        ph = PH_RST; el = 0;
      end else if (ph == PH_REL) begin
        if (el == N * S) begin ph = PH_RUN; rc = 0; end
        else el++;
      end
    end
  endfunction

  function automatic logic [15:0] m_out();
    logic [N-1:0] d;
    d = '1;
    if (ph == PH_REL)
      for (int i = 0; i < N; i++) d[i] = (el < (i + 1) * S);
    else if (ph == PH_RUN)
      d = '0;
    return {(ph == PH_RST) || (ph == PH_FLT), d, ph == PH_RUN,
            ph == PH_FLT, 2'(rc), 8'(lost)};
  endfunction

  function automatic logic [15:0] cur();
    return {pll_rst, domain_rst, ready, fault, retry_cnt, lost_cnt};
  endfunction

  task automatic show_fail(input string nm, input logic [15:0] a,
                           input logic [15:0] e);
    $display("FAIL %s @%0t: got prst=%b drst=%b rdy=%b flt=%b retry=%0d lost=%0d want prst=%b drst=%b rdy=%b flt=%b retry=%0d lost=%0d",
             nm, $time, a[15], a[14:12], a[11], a[10], a[9:8], a[7:0],
             e[15], e[14:12], e[11], e[10], e[9:8], e[7:0]);
  endtask

  initial begin : monitor
    logic [15:0] e, a;
    forever begin
      @(posedge refclk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = cur();
        checks++;
        if (a !== e) begin
          errors++;
          if (errors < 30) show_fail("outputs", a, e);
        end
      end
    end
  end

  task automatic step(input logic sr, input logic pin);
    @(negedge refclk);
    rst = 1'b0;
    soft_restart = sr;
    pll_locked = pin;
    m_edge(sr, pin);
    exp_q.push_back(m_out());
    @(posedge refclk);
  endtask

  task automatic run_n(input int n, input logic pin);
    for (int k = 0; k < n; k++) step(1'b0, pin);
  endtask

  task automatic chk_vec(input string nm, input logic [15:0] e);
    checks++;
    if (cur() !== e) begin errors++; show_fail(nm, cur(), e); end
  endtask

  task automatic chk1(input string nm, input int act, input int e);
    checks++;
    if (act != e) begin
      errors++;
      $display("FAIL %s @%0t: got %0d want %0d", nm, $time, act, e);
    end
  endtask

  task automatic bring_up(input int max);
    int n;
    n = 0;
    while (ph != PH_RUN && n < max) begin step(1'b0, 1'b1); n++; end
    #1;
    chk1("bring_up_ready", int'(ready), 1);
  endtask

  task automatic glitch(input int cycles);
    for (int k = 0; k < cycles; k++) step(1'b0, ((k / 5) % 2) == 0);
  endtask

  task automatic rand_phase(input int segs);
    int len;
    logic p;
    for (int k = 0; k < segs; k++) begin
      len = $urandom_range(1, 40);
      p = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < len; j++)
        step($urandom_range(0, 199) == 0, p);
    end
  endtask

  localparam logic [15:0] RST_VEC = 16'hF000;

  initial begin : stim
    int n;
    m_reset();
    repeat (3) @(posedge refclk);
    #1;
    chk_vec("reset_values", RST_VEC);

    // clean bring-up
    run_n(10, 1'b0);
    run_n(40, 1'b1);
    #1;
    chk1("clean_ready", int'(ready), 1);

    // lock loss in RUN
    run_n(5, 1'b0);
    #1;
    chk1("lost_after_loss", int'(lost_cnt), 1);
    bring_up(60);

    // glitchy lock within the timeout, then past it
    step(1'b1, 1'b1);
    glitch(40);
    bring_up(60);
    step(1'b1, 1'b0);
    glitch(70);
    bring_up(80);

    // never lock
    step(1'b1, 1'b0);
    run_n(3 * (PULSE + TMO) + 10, 1'b0);
    #1;
    chk1("never_lock_fault", int'(fault), 1);
    chk1("never_lock_pll_rst", int'(pll_rst), 1);

    // soft_restart from FAULT, then same cycle as a lock loss
    step(1'b1, 1'b1);
    #1;
    chk1("soft_fault_clear", int'(fault), 0);
    bring_up(60);
    n = lost;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    run_n(3, 1'b0);
    #1;
    chk1("lost_kept_on_soft", int'(lost_cnt), n);

    // async reset in RELEASE with domain_rst = 100
    n = 0;
    while (!(ph == PH_REL && el >= 2 * S) && n < 80) begin
      step(1'b0, 1'b1);
      n++;
    end
    #2;
    chk_vec("before_async_rst", m_out());
    rst = 1'b1;
    m_reset();
    #1;
    chk_vec("async_reset", RST_VEC);
    repeat (2) @(posedge refclk);
    run_n(8, 1'b0);

    rand_phase(150);

    // lost_cnt saturation
    step(1'b1, 1'b1);
    for (int k = 0; k < 257; k++) begin
      bring_up(60);
      run_n(3, 1'b0);
    end
    #1;
    chk1("lost_saturated", int'(lost_cnt), 255);

    repeat (3) @(posedge refclk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
